// File: rtl/ex_stage.sv
// ex_stage: execute stage of the pipeline. It sits directly behind the ID/EX register.
//
// Responsibilities:
//   - selects the forwarded operands;
//   - runs the 16-bit ALU;
//   - holds the condition-code register (CCR: C, N, Z);
//   - resolves jumps for the EX/MEM register and for fetch.
//
// Ports:
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   iRegSrc          source operand from ID/EX
//   iRegDest         destination-register operand from ID/EX
//   iImm             immediate from ID/EX
//   iAluControl      ALU operation (0 NOP .. 10 MOV, 11-15 yield 0)
//   iImmOrReg        1: operand B is iImm, 0: operand B is the forwarded source
//   iUpdateStatus    the ALU op may write Z/N (and C for arithmetic/shift ops)
//   iCarryFlag       00/11 none, 01 SETC, 10 CLRC
//   iBranchFlag      the instruction is a jump
//   iFunCode         jump condition: 000 JZ, 001 JN, 010 JC, 011 JMP, 1xx never
//   fwdSrcSel        00/11 iRegSrc, 01 memFwdData, 10 wbFwdData
//   fwdDestSel       same encoding, applied to iRegDest
//   memFwdData       EX/MEM result available for forwarding
//   wbFwdData        MEM/WB result available for forwarding
//   aluResult        combinational ALU result
//   flags            registered CCR {C,N,Z}
//   branchTaken      combinational redirect request (0 while rst is high)
//   branchTarget     jump address (the forwarded destination register)
//   flushPending     branchTaken delayed by one cycle, used to flush IF/ID
module ex_stage #(
    parameter int WIDTH   = 16,
    parameter int ALU_OPS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   iRegSrc,
    input  logic [WIDTH-1:0]   iRegDest,
    input  logic [WIDTH-1:0]   iImm,
    input  logic [ALU_OPS-1:0] iAluControl,
    input  logic               iImmOrReg,
    input  logic               iUpdateStatus,
    input  logic [1:0]         iCarryFlag,
    input  logic               iBranchFlag,
    input  logic [2:0]         iFunCode,
    input  logic [1:0]         fwdSrcSel,
    input  logic [1:0]         fwdDestSel,
    input  logic [WIDTH-1:0]   memFwdData,
    input  logic [WIDTH-1:0]   wbFwdData,
    output logic [WIDTH-1:0]   aluResult,
    output logic [2:0]         flags,
    output logic               branchTaken,
    output logic [WIDTH-1:0]   branchTarget,
    output logic               flushPending
);

    localparam logic [ALU_OPS-1:0] OP_NOP = ALU_OPS'(0);
    localparam logic [ALU_OPS-1:0] OP_NOT = ALU_OPS'(1);
    localparam logic [ALU_OPS-1:0] OP_INC = ALU_OPS'(2);
    localparam logic [ALU_OPS-1:0] OP_DEC = ALU_OPS'(3);
    localparam logic [ALU_OPS-1:0] OP_ADD = ALU_OPS'(4);
    localparam logic [ALU_OPS-1:0] OP_SUB = ALU_OPS'(5);
    localparam logic [ALU_OPS-1:0] OP_AND = ALU_OPS'(6);
    localparam logic [ALU_OPS-1:0] OP_OR  = ALU_OPS'(7);
    localparam logic [ALU_OPS-1:0] OP_SHL = ALU_OPS'(8);
    localparam logic [ALU_OPS-1:0] OP_SHR = ALU_OPS'(9);
    localparam logic [ALU_OPS-1:0] OP_MOV = ALU_OPS'(10);

    localparam logic [1:0] CF_SETC = 2'b01;
    localparam logic [1:0] CF_CLRC = 2'b10;

    localparam logic [1:0] JC_Z = 2'b00;
    localparam logic [1:0] JC_N = 2'b01;
    localparam logic [1:0] JC_C = 2'b10;

    logic [WIDTH-1:0] op_a, src_val, op_b;
    logic [WIDTH-1:0] result;
    logic [WIDTH:0]   ext;          // ALU result widened by one bit to capture carry/borrow/shift-out
    logic [3:0]       shamt;
    logic             cout, writes_zn, writes_c;
    logic             flag_c, flag_n, flag_z;
    logic             c_next, n_next, z_next;
    logic             cond;

    // Forwarding muxes; encoding 11 falls back to the ID/EX value.
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default first,
        // otherwise a path that skips the assignment infers a latch.
        op_a    = iRegDest;
        src_val = iRegSrc;
        case (fwdDestSel)
            2'b01:   op_a = memFwdData;
            2'b10:   op_a = wbFwdData;
            default: op_a = iRegDest;
        endcase
        case (fwdSrcSel)
            2'b01:   src_val = memFwdData;
            2'b10:   src_val = wbFwdData;
            default: src_val = iRegSrc;
        endcase
    end

    assign op_b  = iImmOrReg ? iImm : src_val;
    assign shamt = op_b[3:0];

    // ALU. Besides the result and carry, it reports which flags the op may write.
    always_comb begin
        result    = '0;
        ext       = '0;
        cout      = 1'b0;
        writes_zn = 1'b0;
        writes_c  = 1'b0;
        case (iAluControl)
            OP_NOP: result = op_a;
            OP_NOT: begin
                result    = ~op_a;
                writes_zn = 1'b1;
            end
            OP_INC: begin
                {cout, result} = {1'b0, op_a} + (WIDTH+1)'(1);
                writes_zn      = 1'b1;
                writes_c       = 1'b1;
            end
            OP_DEC: begin
                // The top bit of the widened difference is the borrow.
                {cout, result} = {1'b0, op_a} - (WIDTH+1)'(1);
                writes_zn      = 1'b1;
                writes_c       = 1'b1;
            end
            OP_ADD: begin
                {cout, result} = {1'b0, op_a} + {1'b0, op_b};
                writes_zn      = 1'b1;
                writes_c       = 1'b1;
            end
            OP_SUB: begin
                {cout, result} = {1'b0, op_a} - {1'b0, op_b};
                writes_zn      = 1'b1;
                writes_c       = 1'b1;
            end
            OP_AND: begin
                result    = op_a & op_b;
                writes_zn = 1'b1;
            end
            OP_OR: begin
                result    = op_a | op_b;
                writes_zn = 1'b1;
            end
            OP_SHL: begin
                // The last bit shifted out lands in the guard bit above the MSB.
                ext       = {1'b0, op_a} << shamt;
                result    = ext[WIDTH-1:0];
                cout      = ext[WIDTH];
                writes_zn = 1'b1;
                writes_c  = (shamt != 4'd0);
            end
            OP_SHR: begin
                // The last bit shifted out lands in the guard bit below the LSB.
                ext       = {op_a, 1'b0} >> shamt;
                result    = ext[WIDTH:1];
                cout      = ext[0];
                writes_zn = 1'b1;
                writes_c  = (shamt != 4'd0);
            end
            OP_MOV:  result = op_b;
            default: result = '0;
        endcase
    end

    assign aluResult    = result;
    assign branchTarget = op_a;

    // Jump conditions test the CCR value held before this edge.
    always_comb begin
        cond = 1'b0;
        if (!iFunCode[2]) begin
            case (iFunCode[1:0])
                JC_Z:    cond = flag_z;
                JC_N:    cond = flag_n;
                JC_C:    cond = flag_c;
                default: cond = 1'b1;
            endcase
        end
    end

    assign branchTaken = iBranchFlag & cond & ~rst;

    // CCR next state. Rules are applied from lowest to highest priority, so each
    // later assignment overrides an earlier one for the same bit.
    always_comb begin
        c_next = flag_c;
        n_next = flag_n;
        z_next = flag_z;
        // A taken conditional jump consumes the flag it tested.
        if (branchTaken) begin
            case (iFunCode[1:0])
                JC_Z:    z_next = 1'b0;
                JC_N:    n_next = 1'b0;
                JC_C:    c_next = 1'b0;
                default: ;
            endcase
        end
        if (iUpdateStatus && writes_zn) begin
            z_next = (result == '0);
            n_next = result[WIDTH-1];
        end
        if (iUpdateStatus && writes_c) c_next = cout;
        if (iCarryFlag == CF_SETC) c_next = 1'b1;
        if (iCarryFlag == CF_CLRC) c_next = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so that every register
    // samples values from before the edge, whatever the order of the statements.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_c       <= 1'b0;
            flag_n       <= 1'b0;
            flag_z       <= 1'b0;
            flushPending <= 1'b0;
        end else begin
            flag_c       <= c_next;
            flag_n       <= n_next;
            flag_z       <= z_next;
            flushPending <= branchTaken;
        end
    end

    assign flags = {flag_c, flag_n, flag_z};

endmodule
